// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_pkg
//  Description : Shared constants for the 3x3 window pipeline: window slot
//                indices (row-major, top-left first), window size and the
//                default pixel width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

  // Window slot indices, row-major from the top-left corner
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  localparam int WIN_SIZE      = 9;
  localparam int PIX_WIDTH_DEF = 8;

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer
//  Description : One image row of pixel storage. Combinational read and
//                registered write share one address, so a read returns the
//                value stored one row earlier at the same column.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
  parameter int width_p = 8,
  parameter int depth_p = 640
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(depth_p)-1:0] addr_i,
  input  logic [width_p-1:0]         wr_data_i,
  output logic [width_p-1:0]         rd_data_o
);

  // Storage needs no reset: the window logic never exposes unwritten entries
  logic [width_p-1:0] r_mem [depth_p];

  assign rd_data_o = r_mem[addr_i];

  // Overwrite the old row entry with the new pixel for this column
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[addr_i] <= wr_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_window_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : line_window_3x3
//  Description : Raster-stream 3x3 window generator. Two chained row buffers
//                supply the two rows above the incoming pixel; a two-column
//                shift register plus the incoming column form the window,
//                which is captured in a single output register with
//                valid/ready handshaking.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_window_3x3
  import sobel_pkg::*;
#(
  parameter int width_p      = PIX_WIDTH_DEF,
  parameter int img_width_p  = 640,
  parameter int img_height_p = 480
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        valid_i,
  input  logic [width_p-1:0]          data_i,
  output logic                        ready_o,
  output logic                        valid_o,
  output logic [WIN_SIZE*width_p-1:0] window_o,
  input  logic                        ready_i
);

  localparam int c_col_w = $clog2(img_width_p);
  localparam int c_row_w = $clog2(img_height_p);

  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(img_width_p - 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(img_height_p - 1);
  localparam logic [c_col_w-1:0] c_col_two  = c_col_w'(2);
  localparam logic [c_row_w-1:0] c_row_two  = c_row_w'(2);

  logic [c_col_w-1:0]                r_col;
  logic [c_row_w-1:0]                r_row;
  logic                              r_valid;
  logic [WIN_SIZE-1:0][width_p-1:0]  r_window;
  // Columns indexed 0=top (row-2), 1=middle (row-1), 2=bottom (row)
  logic [2:0][width_p-1:0]           r_col_m1;
  logic [2:0][width_p-1:0]           r_col_m2;
  logic [2:0][width_p-1:0]           w_col_new;
  logic [width_p-1:0]                w_row_m1_pix;
  logic [width_p-1:0]                w_row_m2_pix;
  logic                              w_accept;
  logic                              w_eligible;

  // Single output register: accept whenever it is empty or being drained
  assign ready_o    = ~r_valid | ready_i;
  assign w_accept   = valid_i & ready_o;
  // Only a pixel with two full rows and columns behind it completes a window
  assign w_eligible = (r_row >= c_row_two) && (r_col >= c_col_two);

  assign w_col_new[0] = w_row_m2_pix;
  assign w_col_new[1] = w_row_m1_pix;
  assign w_col_new[2] = data_i;

  assign valid_o  = r_valid;
  assign window_o = r_window;

  line_buffer #(
    .width_p (width_p),
    .depth_p (img_width_p)
  ) u_lb_row_m1 (
    .clk_i     (clk_i),
    .we_i      (w_accept),
    .addr_i    (r_col),
    .wr_data_i (data_i),
    .rd_data_o (w_row_m1_pix)
  );

  line_buffer #(
    .width_p (width_p),
    .depth_p (img_width_p)
  ) u_lb_row_m2 (
    .clk_i     (clk_i),
    .we_i      (w_accept),
    .addr_i    (r_col),
    .wr_data_i (w_row_m1_pix),
    .rd_data_o (w_row_m2_pix)
  );

  // Raster position of the next pixel; wraps rows and frames with no gap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == c_col_last) begin
        r_col <= '0;
        r_row <= (r_row == c_row_last) ? '0 : r_row + c_row_w'(1);
      end else begin
        r_col <= r_col + c_col_w'(1);
      end
    end
  end

  // Keep the two most recent columns of the three-row band
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_col_m1 <= '0;
      r_col_m2 <= '0;
    end else if (w_accept) begin
      r_col_m2 <= r_col_m1;
      r_col_m1 <= w_col_new;
    end
  end

  // Output register: load on an eligible pixel, otherwise drain on ready_i
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid  <= 1'b0;
      r_window <= '0;
    end else if (w_accept && w_eligible) begin
      r_valid <= 1'b1;
      for (int r = 0; r < 3; r++) begin
        r_window[WIN_TL + 3*r] <= r_col_m2[r];
        r_window[WIN_TC + 3*r] <= r_col_m1[r];
        r_window[WIN_TR + 3*r] <= w_col_new[r];
      end
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_window_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_window_3x3
//  Description : Self-checking bench for line_window_3x3. A 4x4 instance runs
//                directed tables and hand sequences; a 5x3 instance runs
//                random valid/ready traffic. Both are watched by a frame-image
//                reference model that predicts every window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_window_3x3;

  logic clk;
  logic rst_n;

  logic        v4i, r4i, r4o, v4o;
  logic [7:0]  d4;
  logic [71:0] w4;
  logic        v5i, r5i, r5o, v5o;
  logic [7:0]  d5;
  logic [71:0] w5;

  int checks = 0;
  int errors = 0;

  line_window_3x3 #(.width_p(8), .img_width_p(4), .img_height_p(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v4i), .data_i(d4),
    .ready_o(r4o), .valid_o(v4o), .window_o(w4), .ready_i(r4i)
  );

  line_window_3x3 #(.width_p(8), .img_width_p(5), .img_height_p(3)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v5i), .data_i(d5),
    .ready_o(r5o), .valid_o(v5o), .window_o(w5), .ready_i(r5i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Window centred one row/column behind (r,c), read from the stored frame
  function automatic logic [71:0] exp_win(input int img[32], input int w, input int r, input int c);
    logic [71:0] v = '0;
    for (int k = 0; k < 9; k++)
      v[k*8 +: 8] = 8'(img[(r - 2 + k/3)*w + (c - 2 + k%3)]);
    return v;
  endfunction

  // ---------------- reference model, 4x4 instance ----------------
  int          img4 [32];
  int          n4 = 0;
  int          wins4 = 0;
  logic [71:0] q4 [$];

  always @(negedge clk) begin
    int r, c;
    if (!rst_n) begin
      n4 = 0;
      q4.delete();
    end else begin
      if (v4o && r4i) begin
        wins4++;
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon4_unexpected got=%0h exp=none", w4);
        end else begin
          chk("mon4_win", w4, q4.pop_front());
        end
      end
      if (v4i && r4o) begin
        r = n4 / 4; c = n4 % 4;
        img4[r*4 + c] = int'(d4);
        if (r >= 2 && c >= 2) q4.push_back(exp_win(img4, 4, r, c));
        n4 = (n4 + 1) % 16;
      end
    end
  end

  // ---------------- reference model, 5x3 instance ----------------
  int          img5 [32];
  int          n5 = 0;
  int          wins5 = 0;
  logic [71:0] q5 [$];
  logic        hold5 = 1'b0;
  logic [71:0] held5 = '0;

  always @(negedge clk) begin
    int r, c;
    if (!rst_n) begin
      n5 = 0;
      q5.delete();
      hold5 = 1'b0;
    end else begin
      if (hold5) begin
        chk("hold5_valid", v5o, 1'b1);
        chk("hold5_win", w5, held5);
      end
      hold5 = v5o && !r5i;
      held5 = w5;
      if (v5o && r5i) begin
        wins5++;
        if (q5.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon5_unexpected got=%0h exp=none", w5);
        end else begin
          chk("mon5_win", w5, q5.pop_front());
        end
      end
      if (v5i && r5o) begin
        r = n5 / 5; c = n5 % 5;
        img5[r*5 + c] = int'(d5);
        if (r >= 2 && c >= 2) q5.push_back(exp_win(img5, 5, r, c));
        n5 = (n5 + 1) % 15;
      end
    end
  end

  // ---------------- directed table for one 4x4 frame ----------------
  typedef struct {
    int pix;
    bit vld;
    int win[9];
  } vec_t;

  vec_t vec [16];

  function automatic logic [71:0] pack_win(input int win[9], input int base);
    logic [71:0] v = '0;
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(win[k] + base);
    return v;
  endfunction

  task automatic step4(input logic v, input int d, input logic r);
    v4i = v; d4 = 8'(d); r4i = r;
    @(posedge clk); #1;
  endtask

  task automatic run_table(input int base);
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, base + vec[i].pix, 1'b1);
      chk($sformatf("tbl_valid_p%0d", base + i), v4o, vec[i].vld);
      if (vec[i].vld)
        chk($sformatf("tbl_win_p%0d", base + i), w4, pack_win(vec[i].win, base));
    end
  endtask

  task automatic do_reset();
    v4i = 1'b0; v5i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", v4o, 1'b0);
    chk("rst_window", w4, 72'h0);
    chk("rst_ready", r4o, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int acc5, cyc;

    for (int i = 0; i < 16; i++) begin
      vec[i].pix = i;
      vec[i].vld = 1'b0;
      vec[i].win = '{default: 0};
    end
    vec[10].vld = 1'b1; vec[10].win = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    vec[11].vld = 1'b1; vec[11].win = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    vec[14].vld = 1'b1; vec[14].win = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
    vec[15].vld = 1'b1; vec[15].win = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

    rst_n = 1'b0;
    v4i = 1'b0; d4 = '0; r4i = 1'b0;
    v5i = 1'b0; d5 = '0; r5i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid4", v4o, 1'b0);
    chk("init_window4", w4, 72'h0);
    chk("init_ready4", r4o, 1'b1);
    chk("init_valid5", v5o, 1'b0);
    chk("init_ready5", r5o, 1'b1);
    rst_n = 1'b1;

    // Continuous stream, then a second frame back-to-back
    run_table(0);
    run_table(16);

    // Back-pressure: hold the first window, then release
    for (int i = 0; i <= 10; i++) step4(1'b1, i, 1'b1);
    chk("bp_first_valid", v4o, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step4(1'b1, 11, 1'b0);
      chk("bp_hold_valid", v4o, 1'b1);
      chk("bp_hold_win", w4, pack_win(vec[10].win, 0));
      chk("bp_hold_ready", r4o, 1'b0);
    end
    step4(1'b1, 11, 1'b1);
    chk("bp_resume_valid", v4o, 1'b1);
    chk("bp_resume_win", w4, pack_win(vec[11].win, 0));
    for (int i = 12; i <= 15; i++) step4(1'b1, i, 1'b1);
    chk("bp_last_win", w4, pack_win(vec[15].win, 0));
    step4(1'b0, 0, 1'b1);
    chk("bp_drain_valid", v4o, 1'b0);
    chk("frames_win_count", 72'(wins4), 72'd12);

    // Reset with a window pending, then reset after pixel 7, then a clean frame
    for (int i = 0; i <= 10; i++) step4(1'b1, i, 1'b1);
    step4(1'b0, 0, 1'b0);
    chk("pending_valid", v4o, 1'b1);
    do_reset();
    for (int i = 0; i <= 7; i++) step4(1'b1, i, 1'b1);
    do_reset();
    run_table(0);
    step4(1'b0, 0, 1'b1);
    chk("mon4_drained", 72'(q4.size()), 72'd0);

    // Random valid/ready on the 5x3 instance: four frames of random pixels
    acc5 = 0;
    cyc = 0;
    while (acc5 < 60 && cyc < 4000) begin
      v5i = 1'($urandom_range(0, 1));
      d5  = 8'($urandom);
      r5i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (v5i && r5o) acc5++;
      @(posedge clk); #1;
      cyc++;
    end
    v5i = 1'b0;
    r5i = 1'b1;
    cyc = 0;
    while ((q5.size() != 0 || v5o) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_accepted", 72'(acc5), 72'd60);
    chk("rand_drained", 72'(q5.size()), 72'd0);
    chk("rand_win_count", 72'(wins5), 72'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_window_3x3.md
LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 Parameter width_p, default 8: pixel width in bits.
REQ-002 Parameter img_width_p, default 640: pixels per row; legal range 3..4096.
REQ-003 Parameter img_height_p, default 480: rows per frame; legal range 3..4096.
REQ-004 clk_i  input  1  single clock; all logic in this domain.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 valid_i  input  1  upstream pixel valid; driven by the CDC FIFO consumer-side valid.
REQ-007 data_i  input  width_p  raster-order pixel.
REQ-008 ready_o  output  1  block accepts data_i this cycle.
REQ-009 valid_o  output  1  window valid.
REQ-010 window_o  output  9*width_p  3x3 window; slot k occupies bits [k*width_p +: width_p]; k=0 is top-left, k=8 is bottom-right, row-major.
REQ-011 ready_i  input  1  downstream accepts window_o.

Function
REQ-012 A pixel is accepted iff valid_i & ready_o; no state changes on cycles without acceptance, except the output clear in REQ-018.
REQ-013 ready_o = ~valid_o | ready_i (single output register, combinational back-pressure pass-through).
REQ-014 Column counter col (0..img_width_p-1) increments per accepted pixel; at img_width_p-1 it wraps to 0 and row increments.
REQ-015 Row counter row (0..img_height_p-1) wraps to 0 after the pixel at (img_height_p-1, img_width_p-1); frame boundary needs no idle cycle.
REQ-016 Two row buffers of img_width_p entries hold rows row-1 and row-2; the 3x3 shift window holds the last three columns of rows row-2, row-1, row.
REQ-017 Accepting pixel (row,col) with row>=2 and col>=2 loads window_o and sets valid_o on the next clock edge (latency 1); the window is centred on (row-1,col-1), and slot 8 equals that pixel.
REQ-018 Pixels with row<2 or col<2 update buffers and counters but produce no window; on such an acceptance valid_o clears if ready_i was high, else it holds.
REQ-019 valid_o holds, with window_o stable, until ready_i is high; a window is consumed on valid_o & ready_i.
REQ-020 Simultaneous consume and new eligible acceptance: the new window loads, valid_o stays 1, and there is no bubble.
REQ-021 Windows per frame SHALL equal exactly (img_width_p-2)*(img_height_p-2); no window spans a row or frame boundary.
REQ-022 Row buffer contents are not cleared at frame wrap; stale data is never exposed, per REQ-018.

Reset
REQ-023 While rst_ni=0: valid_o=0, window_o=0, col=0, row=0; ready_o therefore reads 1.
REQ-024 Row buffer RAM contents are unspecified after reset and SHALL NOT require reset.
REQ-025 Reset mid-frame discards any pending window; the first pixel after release is treated as (0,0).

Structure
REQ-026 The shared package sobel_pkg SHALL hold: window slot index constants (WIN_TL=0 .. WIN_BR=8), the window size constant 9, and a default pixel width constant of 8.
REQ-027 One sub-module line_buffer (width_p x img_width_p, one write and one read per accepted pixel at address col) SHALL be instantiated twice, chained row-2 <- row-1 <- input.
REQ-028 Counter widths SHALL be $clog2 of the respective parameter.

Verification (img_width_p=4, img_height_p=4, pixels 0..15 raster order, unless stated)
REQ-029 Continuous stream with ready_i=1 -> first valid_o one cycle after accepting pixel 10, window {0,1,2,4,5,6,8,9,10}; then windows ending in 11, 14, 15; 4 windows total.
REQ-030 Hold ready_i=0 after the first window -> valid_o=1, window_o stable, ready_o=0, no pixels accepted; releasing ready_i resumes with the window ending in 11.
REQ-031 Two back-to-back frames (pixels 0..15 then 16..31) -> 8 windows; the second frame's first window is {16,17,18,20,21,22,24,25,26}, with no frame-1 data.
REQ-032 Assert rst_ni=0 asynchronously after pixel 7, then send pixels 0..15 -> valid_o drops immediately; the output matches REQ-029 exactly.
REQ-033 Random valid_i/ready_i toggling at 50% with img_width_p=5, img_height_p=3 -> windows equal the golden model in order, 3 windows, none lost or duplicated.
